mcu_debug_stub: RTL and testbench
=================================

Name: mcu_debug_stub

Overview:
- Parametrised hardware stand-in for the RISC-V MCU behind the UART debug controller (mcu_controller), used in board-level bring-up of the debugger.
- Accepts decoded debugger commands (pause, resume, status, memory and register read/write) on a valid strobe.
- Models MCU access latency with a configurable busy window, and holds a small data memory and register file.
- Reports read data and errors the way the real MCU debug port does.

Parameters:
- WIDTH, 32: data/address width; also the width of the tick counter.
- MEM_DEPTH, 64: data memory depth in WIDTH-bit words; power of two, minimum 2.
- REG_COUNT, 32: register file entries; reg 0 is hardwired to zero.
- BUSY_CYCLES, 8: number of cycles busy stays high per command; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- valid  in  1  command strobe, sampled on the rising edge of clk
- cmd  in  4  command code
- addr  in  WIDTH  byte address (memory) or register index
- d_in  in  WIDTH  write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on the completion cycle
- d_rd  out  WIDTH  read result
- error  out  1  result status of the last completed command
- paused  out  1  MCU halted
- overrun  out  1  sticky flag: a valid strobe arrived while busy

Behaviour:
- Reset (async, rst=1):
  - State returns to IDLE.
  - busy=0, done=0, d_rd=0, error=0, paused=0, overrun=0.
  - tick=0; all registers are cleared to 0.
  - Memory contents are not reset (undefined until written).
  - Reset during BUSY aborts the command; nothing is committed.
- Commands: 1 PAUSE, 2 RESUME, 3 STATUS, 4 MEM_RD, 5 MEM_WR, 6 REG_RD, 7 REG_WR. Any other code completes with error=1 and changes no state.
- States:
  - IDLE: valid=1 latches cmd, addr and d_in, loads the counter with BUSY_CYCLES, and moves to BUSY. busy goes high on the next cycle.
  - BUSY: the counter decrements each cycle. When the counter reaches 1, that cycle is the completion cycle: done=1, results commit, and the state returns to IDLE. busy is high for exactly BUSY_CYCLES cycles.
  - A new valid is accepted in the first cycle after the completion cycle (back-to-back allowed).
- valid while busy=1: ignored, overrun set to 1; it stays 1 until rst.
- Results: d_rd and error are registered, update only on the completion cycle, and hold until the next completion.
- tick: free-running WIDTH-bit counter. It increments every cycle while paused=0 and wraps from all-ones to 0.
- PAUSE: paused=1 at completion; tick freezes from the next cycle. Issuing it while already paused is a no-op with error=0.
- RESUME: paused=0 at completion. Issuing it while not paused is a no-op with error=0.
- STATUS: d_rd = tick value at the completion cycle; error=0. Allowed in either run state.
- MEM_RD / MEM_WR:
  - Require paused=1.
  - Word index = addr >> 2.
  - error=1, with no write and d_rd unchanged, when any of these hold: not paused, addr[1:0] != 0, or word index >= MEM_DEPTH.
  - The write commits on the completion cycle.
- REG_RD / REG_WR:
  - Require paused=1.
  - addr >= REG_COUNT, or not paused, gives error=1.
  - A write to reg 0 is silently dropped (error=0); a read of reg 0 returns 0.
- Read-after-write to the same location on consecutive commands returns the new data.
- rst and valid in the same cycle: rst wins.

Test Plan:
- Reset, then idle 10 cycles, then STATUS with BUSY_CYCLES=8 → busy high 8 cycles, done pulses once, d_rd equals the tick count at completion (nonzero, increasing), error=0.
- PAUSE, then STATUS twice 20 cycles apart → both d_rd values are identical; paused=1.
- Paused: MEM_WR addr=0x10, d_in=0xDEADBEEF, then MEM_RD addr=0x10 → d_rd=0xDEADBEEF, error=0.
- Paused: MEM_RD addr=0x12 → error=1. MEM_RD addr=0x100 (MEM_DEPTH=64) → error=1. In both cases d_rd keeps its previous value.
- Paused: REG_WR addr=0 with 0x1234 gives error=0, then REG_RD addr=0 gives d_rd=0. REG_WR addr=5 with 0xA5A5A5A5 then REG_RD addr=5 gives 0xA5A5A5A5. REG_RD addr=32 gives error=1.
- Error and abort cases, each checked separately:
  - After RESUME, a MEM_WR → error=1 and memory is unchanged.
  - valid pulsed mid-busy → overrun=1 and that command is not executed.
  - rst asserted mid-MEM_WR → all outputs return to their reset values and a later read shows the old data.
  - cmd=0xF → error=1.

Source files
------------

// File: rtl/mcu_debug_stub_if.sv
// rtl/mcu_debug_stub_if.sv - debugger command/response bundle for the MCU stand-in
interface mcu_debug_stub_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [3:0]       cmd;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] d_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d_rd;
    logic             error;
    logic             paused;
    logic             overrun;

    modport master (
        output valid, cmd, addr, d_in,
        input  busy, done, d_rd, error, paused, overrun
    );

    modport slave (
        input  valid, cmd, addr, d_in,
        output busy, done, d_rd, error, paused, overrun
    );
endinterface

// File: rtl/mcu_debug_stub.sv
// rtl/mcu_debug_stub.sv - MCU debug-port stand-in with busy window, data memory and register file
module mcu_debug_stub #(
    parameter int WIDTH       = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int REG_COUNT   = 32,
    parameter int BUSY_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    mcu_debug_stub_if.slave  dbg
);
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int REG_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int CNT_W  = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] C_PAUSE  = 4'd1;
    localparam logic [3:0] C_RESUME = 4'd2;
    localparam logic [3:0] C_STATUS = 4'd3;
    localparam logic [3:0] C_MEM_RD = 4'd4;
    localparam logic [3:0] C_MEM_WR = 4'd5;
    localparam logic [3:0] C_REG_RD = 4'd6;
    localparam logic [3:0] C_REG_WR = 4'd7;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [WIDTH-1:0] d_rd_q, d_rd_d;
    logic             error_q, error_d;
    logic             paused_q, paused_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] tick_q, tick_d;

    logic [WIDTH-1:0] regs_q [0:REG_COUNT-1];
    logic [WIDTH-1:0] mem    [0:MEM_DEPTH-1];

    logic              complete;
    logic [WIDTH-1:0]  word_idx;
    logic              mem_ok;
    logic              reg_ok;
    logic [MEM_AW-1:0] mem_idx;
    logic [REG_AW-1:0] reg_idx;
    logic              mem_we;
    logic              reg_we;

    // Address decode for the latched command; memory needs word alignment and range, both need halt
    always_comb begin
        complete = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
        word_idx = addr_q >> 2;
        mem_ok   = paused_q && (addr_q[1:0] == 2'b00) && (word_idx < WIDTH'(MEM_DEPTH));
        reg_ok   = paused_q && (addr_q < WIDTH'(REG_COUNT));
        mem_idx  = word_idx[MEM_AW-1:0];
        reg_idx  = addr_q[REG_AW-1:0];
    end

    // Command sequencing: latch in IDLE, count down in BUSY, commit all results on the last busy cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        din_d     = din_q;
        d_rd_d    = d_rd_q;
        error_d   = error_q;
        paused_d  = paused_q;
        overrun_d = overrun_q;
        tick_d    = paused_q ? tick_q : tick_q + 1'b1;
        mem_we    = 1'b0;
        reg_we    = 1'b0;

        if (dbg.valid && (state_q == S_BUSY)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (dbg.valid) begin
                    cmd_d   = dbg.cmd;
                    addr_d  = dbg.addr;
                    din_d   = dbg.d_in;
                    cnt_d   = CNT_W'(BUSY_CYCLES);
                    state_d = S_BUSY;
                end
            end
            default: begin
                if (!complete) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                    case (cmd_q)
                        C_PAUSE: begin
                            paused_d = 1'b1;
                            error_d  = 1'b0;
                        end
                        C_RESUME: begin
                            paused_d = 1'b0;
                            error_d  = 1'b0;
                        end
                        C_STATUS: begin
                            d_rd_d  = tick_q;
                            error_d = 1'b0;
                        end
                        C_MEM_RD: begin
                            error_d = !mem_ok;
                            if (mem_ok) begin
                                d_rd_d = mem[mem_idx];
                            end
                        end
                        C_MEM_WR: begin
                            error_d = !mem_ok;
                            mem_we  = mem_ok;
                        end
                        C_REG_RD: begin
                            error_d = !reg_ok;
                            if (reg_ok) begin
                                d_rd_d = (addr_q == '0) ? '0 : regs_q[reg_idx];
                            end
                        end
                        C_REG_WR: begin
                            error_d = !reg_ok;
                            reg_we  = reg_ok && (addr_q != '0);
                        end
                        default: begin
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    // Control and result state; reset aborts any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            d_rd_q    <= '0;
            error_q   <= 1'b0;
            paused_q  <= 1'b0;
            overrun_q <= 1'b0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            d_rd_q    <= d_rd_d;
            error_q   <= error_d;
            paused_q  <= paused_d;
            overrun_q <= overrun_d;
            tick_q    <= tick_d;
        end
    end

    // Register file; entry 0 is never written so it reads back as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[reg_idx] <= din_q;
        end
    end

    // Data memory keeps its contents across reset, like the real MCU SRAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= din_q;
        end
    end

    assign dbg.busy    = (state_q == S_BUSY);
    assign dbg.done    = complete;
    assign dbg.d_rd    = d_rd_q;
    assign dbg.error   = error_q;
    assign dbg.paused  = paused_q;
    assign dbg.overrun = overrun_q;
endmodule

// File: tb/tb_mcu_debug_stub.sv
// tb/tb_mcu_debug_stub.sv - self-checking bench for mcu_debug_stub
module tb_mcu_debug_stub;
    localparam int WIDTH       = 32;
    localparam int MEM_DEPTH   = 64;
    localparam int REG_COUNT   = 32;
    localparam int BUSY_CYCLES = 8;

    localparam logic [3:0] C_PAUSE  = 4'd1;
    localparam logic [3:0] C_RESUME = 4'd2;
    localparam logic [3:0] C_STATUS = 4'd3;
    localparam logic [3:0] C_MEM_RD = 4'd4;
    localparam logic [3:0] C_MEM_WR = 4'd5;
    localparam logic [3:0] C_REG_RD = 4'd6;
    localparam logic [3:0] C_REG_WR = 4'd7;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic [31:0] din;
        logic        err;
        logic        upd;
        logic [31:0] d;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        err;
        logic        paused;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    logic        tb_paused;
    logic [31:0] last_d;
    logic [31:0] frozen;
    sb_t         sb_q [$];
    vec_t        vecs [16];

    mcu_debug_stub_if #(.WIDTH(WIDTH)) dbg ();

    mcu_debug_stub #(
        .WIDTH(WIDTH), .MEM_DEPTH(MEM_DEPTH),
        .REG_COUNT(REG_COUNT), .BUSY_CYCLES(BUSY_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dbg(dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release: equals the DUT tick while it runs
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    {31'd0, dbg.busy},    32'd0);
        check({tag, "_done"},    {31'd0, dbg.done},    32'd0);
        check({tag, "_d_rd"},    dbg.d_rd,             32'd0);
        check({tag, "_error"},   {31'd0, dbg.error},   32'd0);
        check({tag, "_paused"},  {31'd0, dbg.paused},  32'd0);
        check({tag, "_overrun"}, {31'd0, dbg.overrun}, 32'd0);
    endtask

    // Issue one command, optionally pulse a second valid mid-busy, then score the result
    task automatic run_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] di,
                           input logic exp_err, input logic upd, input logic [31:0] exp_d,
                           input int inject);
        int  c0;
        int  bcnt;
        bit  seen;
        sb_t e;
        sb_t g;
        @(negedge clk);
        c0       = cyc;
        e.err    = exp_err;
        e.d      = upd ? exp_d : last_d;
        if (c == C_STATUS) e.d = tb_paused ? frozen : 32'(c0 + BUSY_CYCLES);
        e.paused = (c == C_PAUSE) ? 1'b1 : (c == C_RESUME) ? 1'b0 : tb_paused;
        sb_q.push_back(e);
        dbg.valid = 1'b1;
        dbg.cmd   = c;
        dbg.addr  = a;
        dbg.d_in  = di;
        @(posedge clk);
        #1 dbg.valid = 1'b0;
        bcnt = 0;
        seen = 1'b0;
        for (int n = 1; n <= 64 && !seen; n++) begin
            @(negedge clk);
            dbg.valid = (inject != 0) && (n == inject);
            if (dbg.valid) begin
                dbg.cmd  = C_REG_WR;
                dbg.addr = 32'd9;
                dbg.d_in = 32'h99;
            end
            if (dbg.busy) bcnt++;
            if (dbg.done) seen = 1'b1;
        end
        dbg.valid = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout cmd=%0d actual=no_done required=done", c);
        end
        check("busy_cycles", 32'(bcnt), 32'(BUSY_CYCLES));
        @(negedge clk);
        g = sb_q.pop_front();
        check("d_rd",       dbg.d_rd,               g.d);
        check("error",      {31'd0, dbg.error},     {31'd0, g.err});
        check("paused",     {31'd0, dbg.paused},    {31'd0, g.paused});
        check("done_pulse", {31'd0, dbg.done},      32'd0);
        last_d = g.d;
        if (c == C_PAUSE && !tb_paused) frozen = 32'(c0 + BUSY_CYCLES + 1);
        tb_paused = g.paused;
    endtask

    initial begin
        logic [31:0] s1;
        logic [31:0] s2;
        checks    = 0;
        failures  = 0;
        tb_paused = 1'b0;
        last_d    = 32'd0;
        frozen    = 32'd0;
        dbg.valid = 1'b0;
        dbg.cmd   = 4'd0;
        dbg.addr  = 32'd0;
        dbg.d_in  = 32'd0;

        vecs[0]  = '{C_MEM_WR, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{C_MEM_RD, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{C_MEM_RD, 32'h12,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[3]  = '{C_MEM_RD, 32'h100, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[4]  = '{C_MEM_WR, 32'hFC,  32'h0BADF00D, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{C_MEM_RD, 32'hFC,  32'h0,        1'b0, 1'b1, 32'h0BADF00D};
        vecs[6]  = '{C_REG_WR, 32'd0,   32'h1234,     1'b0, 1'b0, 32'h0};
        vecs[7]  = '{C_REG_RD, 32'd0,   32'h0,        1'b0, 1'b1, 32'h0};
        vecs[8]  = '{C_REG_WR, 32'd5,   32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{C_REG_RD, 32'd5,   32'h0,        1'b0, 1'b1, 32'hA5A5A5A5};
        vecs[10] = '{C_REG_RD, 32'd32,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[11] = '{C_REG_WR, 32'd31,  32'h13579BDF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{C_REG_RD, 32'd31,  32'h0,        1'b0, 1'b1, 32'h13579BDF};
        vecs[13] = '{4'hF,     32'h10,  32'h0,        1'b1, 1'b0, 32'h0};
        vecs[14] = '{C_PAUSE,  32'h0,   32'h0,        1'b0, 1'b0, 32'h0};
        vecs[15] = '{C_MEM_RD, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        run_cmd(C_STATUS, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        s1 = dbg.d_rd;
        check("status_nonzero", {31'd0, (s1 != 32'd0)}, 32'd1);
        run_cmd(C_STATUS, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        check("status_increasing", {31'd0, (dbg.d_rd > s1)}, 32'd1);

        run_cmd(C_PAUSE, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        run_cmd(C_STATUS, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        s1 = dbg.d_rd;
        repeat (20) @(negedge clk);
        run_cmd(C_STATUS, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        s2 = dbg.d_rd;
        check("frozen_tick_equal", s2, s1);

        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].addr, vecs[i].din,
                    vecs[i].err, vecs[i].upd, vecs[i].d, 0);
        end

        run_cmd(C_RESUME, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        run_cmd(C_MEM_WR, 32'h10, 32'h11111111, 1'b1, 1'b0, 32'h0, 0);
        run_cmd(C_RESUME, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        run_cmd(C_PAUSE, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        run_cmd(C_MEM_RD, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 0);

        check("overrun_clear", {31'd0, dbg.overrun}, 32'd0);
        run_cmd(C_REG_WR, 32'd8, 32'h88, 1'b0, 1'b0, 32'h0, 3);
        check("overrun_set", {31'd0, dbg.overrun}, 32'd1);
        run_cmd(C_REG_RD, 32'd9, 32'h0, 1'b0, 1'b1, 32'h0, 0);
        run_cmd(C_REG_RD, 32'd8, 32'h0, 1'b0, 1'b1, 32'h88, 0);
        check("overrun_sticky", {31'd0, dbg.overrun}, 32'd1);

        @(negedge clk);
        dbg.valid = 1'b1;
        dbg.cmd   = C_MEM_WR;
        dbg.addr  = 32'h10;
        dbg.d_in  = 32'h55555555;
        @(posedge clk);
        #1 dbg.valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", {31'd0, dbg.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst       = 1'b0;
        tb_paused = 1'b0;
        last_d    = 32'd0;
        run_cmd(C_PAUSE, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
        run_cmd(C_MEM_RD, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 0);
        run_cmd(C_REG_RD, 32'd5, 32'h0, 1'b0, 1'b1, 32'h0, 0);
        check("overrun_after_reset", {31'd0, dbg.overrun}, 32'd0);
        run_cmd(4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
